mux_nto1_stream: RTL and testbench
==================================

Name: mux_nto1_stream

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output and valid/ready handshake on every input and on the output.
- Replaces the fixed 8:1 scalar combinational mux trees in stream datapaths.
- Two modes:
  - fixed-select: the `sel` port chooses the channel.
  - round-robin: fair arbitration among valid channels.
- Sits between N producer streams and one consumer; has one output register stage.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 8, number of input channels (2..64; need not be a power of two).
- SELW, $clog2(NCH), channel-index width (localparam, derived, not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed-select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed-select mode.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- out_data  output  WIDTH  registered data.
- out_ch  output  SELW  registered index of the source channel of out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - RR pointer ptr = NCH-1, so channel 0 has first priority.
- load_en = !out_valid || out_ready. The output stage accepts one beat per cycle when load_en is high.
- Grant selection (combinational, evaluated every cycle):
  - mode=0: grant = sel, gvalid = in_valid[sel]. If sel >= NCH, then gvalid = 0 and no channel is ever granted.
  - mode=1: grant = first i with in_valid[i] set, scanning ptr+1, ptr+2, ... modulo NCH (wraps NCH-1 -> 0). gvalid = |in_valid.
- in_ready[i] = load_en && gvalid && (i == grant); all other bits are 0. At most one in_ready bit is high per cycle.
- Transfer on input i = in_valid[i] && in_ready[i].
- On a transfer, at the next edge:
  - out_data <= in_data[grant], out_ch <= grant, out_valid <= 1.
  - In mode=1 only, ptr <= grant. In mode=0, ptr is unchanged.
- If load_en && !gvalid: out_valid <= 0. out_data and out_ch hold their previous values.
- If !load_en (out_valid && !out_ready): out_valid, out_data and out_ch hold (output stall). No in_ready is asserted.
- Latency: 1 cycle from input transfer to out_valid. Full throughput: 1 beat per cycle while out_ready = 1.
- Simultaneous output consume and new input accept in the same cycle is allowed; no bubble.
- Mode or sel changes take effect in the same cycle for grant. A beat already held in the output register is unaffected. ptr is retained across mode switches.
- Fairness (mode=1): with all channels valid and out_ready = 1, grants cycle 0,1,...,NCH-1,0,... Any continuously valid channel is served within NCH accepted beats.
- Output stability rule: while out_valid && !out_ready, out_data and out_ch must not change.
- Reset asserted mid-stream drops the held beat; out_valid falls immediately (asynchronous).
- Protocol rule on inputs: producers must not drop in_valid without a transfer. The block does not check this.

Decomposition:
- Package mux_stream_pkg:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1 constants.
  - A function clog2_min1 returning at least 1 for the SELW derivation.
- Sub-module mux_rr_grant (combinational).
  - Inputs: req[NCH], ptr[SELW].
  - Outputs: grant[SELW], any.
  - Implementation: rotate-priority encoder via a double-width request vector.
- Top level holds ptr, the output register, mode muxing and in_ready generation.

Test Plan (NCH=8, WIDTH=8):
- Reset: hold rst_n = 0 with random inputs -> out_valid = 0, out_data = 0x00, out_ch = 0, in_ready = 0x00. Release reset, mode=1, in_valid = 0xFF, out_ready = 1 -> first out_ch = 0.
- Fixed mode: mode=0, sel=5, in_data[5] = 0xA5, in_valid = 0x20, out_ready = 1 -> in_ready = 0x20. Next cycle out_data = 0xA5, out_ch = 5, out_valid = 1. Then set sel=3 with in_valid[3] = 0 -> out_valid drops to 0 after one cycle.
- Round-robin fairness: mode=1, in_valid = 0xFF for 16 cycles, channel i data = 0x10+i -> out_ch sequence 0..7,0..7 and out_data 0x10..0x17 repeated, no bubbles.
- Sparse round-robin with wrap: in_valid = 0x81 -> grants alternate 0,7,0,7. Then with ptr = 7 and in_valid = 0x84 -> next grant is 2.
- Backpressure: out_ready = 0 for 4 cycles while out_valid = 1 with out_data = 0x33 -> out_data and out_ch stable, in_ready = 0x00. Raise out_ready -> the next granted beat appears the following cycle.
- Async reset mid-stream: assert rst_n low between clock edges while out_valid = 1 -> out_valid = 0 immediately. After release, mode=1 arbitration restarts at channel 0.

Source files
------------

// File: rtl/mux_nto1_stream_pkg.sv
// Shared constants and helpers for the N:1 streaming multiplexer.
// The mode encodings are used by the top level and by the bench.
package mux_stream_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel-index width; a 2-channel mux still needs one select bit.
    function automatic int clog2_min1(input int n);
        int w;
        if (n <= 2) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_nto1_stream_if.sv
// Stream bundle between N producers, the mux and one consumer.
// slave is the mux view; master is the producer/consumer environment view.
interface mux_nto1_stream_if
    import mux_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 8
);
    localparam int SELW = clog2_min1(NCH);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_ch,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_ch,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/mux_nto1_stream_rr_grant.sv
// Rotating-priority encoder: first set request after ptr, wrapping at NCH.
// Uses a doubled request vector so the rotation is a single part-select.
module mux_rr_grant
    import mux_stream_pkg::*;
#(
    parameter  int NCH  = 8,
    localparam int SELW = clog2_min1(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            any
);

    logic [2*NCH-1:0] dbl_s;
    logic [NCH-1:0]   rot_s;
    logic [SELW:0]    shamt_s;
    logic [SELW-1:0]  off_s;
    logic [SELW+1:0]  sum_s;

    // Rotate so bit 0 is channel ptr+1, then pick the lowest set offset.
    always_comb begin
        dbl_s   = {req, req};
        shamt_s = {1'b0, ptr} + {{SELW{1'b0}}, 1'b1};
        rot_s   = dbl_s[shamt_s +: NCH];
        off_s   = {SELW{1'b0}};
        for (int k = NCH - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? SELW'(k) : off_s;
        end
        sum_s = (SELW+2)'(shamt_s) + (SELW+2)'(off_s);
        if (sum_s >= (SELW+2)'(NCH)) begin
            grant = SELW'(sum_s - (SELW+2)'(NCH));
        end else begin
            grant = SELW'(sum_s);
        end
        any = |req;
    end

endmodule

// File: rtl/mux_nto1_stream.sv
// N-channel W-bit stream multiplexer with a single registered output stage.
// Fixed-select or round-robin grant; in_ready is combinational from the grant.
module mux_nto1_stream
    import mux_stream_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 8,
    localparam int SELW  = clog2_min1(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    mux_nto1_stream_if.slave bus
);

    localparam int SELSPAN = 1 << SELW;

    logic [SELW-1:0]    ptr_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [SELW-1:0]    out_ch_r;
    logic               out_valid_r;

    logic               load_en_s;
    logic [SELW-1:0]    rr_grant_s;
    logic               rr_any_s;
    logic [SELSPAN-1:0] vext_s;
    logic [SELW-1:0]    grant_s;
    logic               gvalid_s;
    logic [WIDTH-1:0]   gdata_s;
    logic [NCH-1:0]     in_ready_s;

    mux_rr_grant #(
        .NCH (NCH)
    ) u_rr_grant (
        .req   (bus.in_valid),
        .ptr   (ptr_r),
        .grant (rr_grant_s),
        .any   (rr_any_s)
    );

    assign load_en_s = !out_valid_r || bus.out_ready;

    // Mode mux. Zero-extending in_valid makes an out-of-range sel read as not valid.
    always_comb begin
        vext_s          = {SELSPAN{1'b0}};
        vext_s[NCH-1:0] = bus.in_valid;
        if (mode == MODE_RR) begin
            grant_s  = rr_grant_s;
            gvalid_s = rr_any_s;
        end else begin
            grant_s  = sel;
            gvalid_s = vext_s[sel];
        end
    end

    // Data select and one-hot ready; nothing is accepted while reset is held.
    always_comb begin
        gdata_s    = {WIDTH{1'b0}};
        in_ready_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (grant_s == SELW'(i)) begin
                gdata_s       = bus.in_data[i*WIDTH +: WIDTH];
                in_ready_s[i] = rst_n && load_en_s && gvalid_s;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= SELW'(NCH - 1);
            out_data_r  <= {WIDTH{1'b0}};
            out_ch_r    <= {SELW{1'b0}};
            out_valid_r <= 1'b0;
        end else if (load_en_s) begin
            if (gvalid_s) begin
                out_data_r  <= gdata_s;
                out_ch_r    <= grant_s;
                out_valid_r <= 1'b1;
                if (mode == MODE_RR) begin
                    ptr_r <= grant_s;
                end else begin
                    ptr_r <= ptr_r;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_data_r  <= out_data_r;
            out_ch_r    <= out_ch_r;
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_data  = out_data_r;
    assign bus.out_ch    = out_ch_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench for mux_nto1_stream (NCH=8, WIDTH=8) with hand-computed expectations.
module tb_mux_nto1_stream;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [2:0] sel;

    int vectors;
    int miscompares;

    mux_nto1_stream_if #(.WIDTH(8), .NCH(8)) bus ();

    mux_nto1_stream #(
        .WIDTH (8),
        .NCH   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .sel   (sel),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] d);
        bus.in_data[ch*8 +: 8] = d;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n         = 1'b0;
        mode          = 1'b0;
        sel           = 3'd0;
        bus.in_data   = 64'd0;
        bus.in_valid  = 8'd0;
        bus.out_ready = 1'b0;

        // Reset held with random inputs.
        for (int c = 0; c < 3; c++) begin
            mode          = 1'($urandom_range(0, 1));
            sel           = 3'($urandom_range(0, 7));
            bus.in_data   = {$urandom, $urandom};
            bus.in_valid  = 8'($urandom_range(1, 255));
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_out_data",  64'(bus.out_data),  64'h00);
            check("rst_out_ch",    64'(bus.out_ch),    64'd0);
            check("rst_in_ready",  64'(bus.in_ready),  64'h00);
            tick();
        end

        // Release; round-robin with all channels valid starts at 0 and cycles.
        for (int i = 0; i < 8; i++) set_ch(i, 8'(8'h10 + i));
        rst_n         = 1'b1;
        mode          = 1'b1;
        bus.in_valid  = 8'hFF;
        bus.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            check("rr_in_ready", 64'(bus.in_ready), 64'(8'h01 << (k % 8)));
            tick();
            check("rr_out_ch",    64'(bus.out_ch),    64'(k % 8));
            check("rr_out_data",  64'(bus.out_data),  64'(8'h10 + (k % 8)));
            check("rr_out_valid", 64'(bus.out_valid), 64'd1);
        end

        // Fixed select on channel 5.
        mode         = 1'b0;
        sel          = 3'd5;
        set_ch(5, 8'hA5);
        bus.in_valid = 8'h20;
        #1;
        check("fix_in_ready", 64'(bus.in_ready), 64'h20);
        tick();
        check("fix_out_data",  64'(bus.out_data),  64'hA5);
        check("fix_out_ch",    64'(bus.out_ch),    64'd5);
        check("fix_out_valid", 64'(bus.out_valid), 64'd1);

        // Selected channel idle: output drains, data/ch hold.
        sel = 3'd3;
        #1;
        check("fix_idle_in_ready", 64'(bus.in_ready), 64'h00);
        tick();
        check("fix_idle_out_valid", 64'(bus.out_valid), 64'd0);
        check("fix_idle_out_data",  64'(bus.out_data),  64'hA5);
        check("fix_idle_out_ch",    64'(bus.out_ch),    64'd5);

        // Sparse round-robin with wrap; pointer retained at 7 across mode switch.
        mode         = 1'b1;
        bus.in_valid = 8'h81;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("sparse_out_ch",   64'(bus.out_ch),   (k % 2 == 0) ? 64'd0 : 64'd7);
            check("sparse_out_data", 64'(bus.out_data), (k % 2 == 0) ? 64'h10 : 64'h17);
        end
        bus.in_valid = 8'h84;
        #1;
        check("wrap_in_ready", 64'(bus.in_ready), 64'h04);
        tick();
        check("wrap_out_ch",   64'(bus.out_ch),   64'd2);
        check("wrap_out_data", 64'(bus.out_data), 64'h12);

        // Load 0x33 from channel 3 in fixed mode, then stall the consumer.
        mode         = 1'b0;
        sel          = 3'd3;
        set_ch(3, 8'h33);
        bus.in_valid = 8'h08;
        tick();
        check("bp_load_data", 64'(bus.out_data), 64'h33);
        bus.out_ready = 1'b0;
        mode          = 1'b1;
        bus.in_valid  = 8'hF0;
        #1;
        check("bp_in_ready0", 64'(bus.in_ready), 64'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_out_data",  64'(bus.out_data),  64'h33);
            check("bp_out_ch",    64'(bus.out_ch),    64'd3);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready",  64'(bus.in_ready),  64'h00);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(bus.in_ready), 64'h10);
        tick();
        check("bp_release_out_ch",   64'(bus.out_ch),   64'd4);
        check("bp_release_out_data", 64'(bus.out_data), 64'h14);

        // Asynchronous reset between edges drops the held beat at once.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_out_data",  64'(bus.out_data),  64'h00);
        check("arst_out_ch",    64'(bus.out_ch),    64'd0);
        check("arst_in_ready",  64'(bus.in_ready),  64'h00);
        tick();
        rst_n        = 1'b1;
        mode         = 1'b1;
        bus.in_valid = 8'hFF;
        #1;
        check("arst_restart_in_ready", 64'(bus.in_ready), 64'h01);
        tick();
        check("arst_restart_out_ch",    64'(bus.out_ch),    64'd0);
        check("arst_restart_out_valid", 64'(bus.out_valid), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
